// File: rtl/hifigan_fixed_pkg.sv
// Fixed-point formats and FSM state type shared by the HiFi-GAN datapath blocks.
package hifigan_fixed_pkg;

    // Activation Q4.12, weight Q2.14, product/accumulator output Q6.26
    localparam int unsigned ACT_W      = 16;
    localparam int unsigned ACT_FRAC   = 12;
    localparam int unsigned WGT_W      = 16;
    localparam int unsigned WGT_FRAC   = 14;
    localparam int unsigned ACC_Q_W    = 32;
    localparam int unsigned ACC_Q_FRAC = 26;

    localparam logic [ACC_Q_W-1:0] Q626_MAX = 32'h7FFF_FFFF;
    localparam logic [ACC_Q_W-1:0] Q626_MIN = 32'h8000_0000;

    typedef enum logic {
        MAC_IDLE,
        MAC_ACCUM
    } mac_state_t;

endpackage

// File: rtl/mac_accum_16_32_if.sv
// Beat input and window-result output of the conv1d MAC stage.
interface mac_accum_16_32_if;
    import hifigan_fixed_pkg::*;

    logic                       i_valid;
    logic                       o_ready;
    logic                       i_first;
    logic                       i_last;
    logic signed [ACT_W-1:0]    i_data;
    logic signed [WGT_W-1:0]    i_weight;
    logic signed [ACC_Q_W-1:0]  i_bias;
    logic signed [ACC_Q_W-1:0]  o_acc_raw;
    logic                       o_valid;
    logic                       o_sat;
    logic                       o_err;

    modport master (
        output i_valid, i_first, i_last, i_data, i_weight, i_bias,
        input  o_ready, o_acc_raw, o_valid, o_sat, o_err
    );

    modport slave (
        input  i_valid, i_first, i_last, i_data, i_weight, i_bias,
        output o_ready, o_acc_raw, o_valid, o_sat, o_err
    );

endinterface

// File: rtl/sat_narrow.sv
// Combinational signed clamp from IN_W to OUT_W bits with a clamped flag.
module sat_narrow #(
    parameter int unsigned IN_W  = 40,
    parameter int unsigned OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  wide,
    output logic signed [OUT_W-1:0] narrow,
    output logic                    clamped
);

    // Bits that must all equal the sign for the value to fit in OUT_W
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = wide[IN_W-1:OUT_W-1];

    // Pass the low bits through when in range, otherwise clamp toward the sign
    always_comb begin
        clamped = !((&top_bits) || !(|top_bits));
        narrow  = wide[OUT_W-1:0];
        if (clamped) begin
            if (wide[IN_W-1]) begin
                narrow = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                narrow = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/mac_accum_16_32.sv
// Conv1d multiply-accumulate: Q4.12 x Q2.14 products summed onto a Q6.26 bias
// per window, saturated to 32 bits. Stage 1 multiplies and runs the window FSM,
// stage 2 accumulates and emits.
module mac_accum_16_32
    import hifigan_fixed_pkg::*;
#(
    parameter int unsigned MAX_TAPS = 64,
    parameter int unsigned GUARD    = 8
) (
    input logic              clk,
    input logic              rst_n,
    mac_accum_16_32_if.slave bus
);

    localparam int unsigned ACC_W  = ACC_Q_W + GUARD;
    localparam int unsigned TCNT_W = $clog2(MAX_TAPS + 1) + 1;

    mac_state_t          state_q, state_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
    logic                ready_q;
    logic                accept;
    logic                kill;
    logic                err_d, err_q;

    logic                live1_q, first1_q, last1_q;
    logic signed [ACC_Q_W-1:0] prod1_q, bias1_q;
    logic signed [ACC_Q_W-1:0] prod_d;

    logic signed [ACC_W-1:0]   acc_q, acc_next;
    logic signed [ACC_Q_W-1:0] sat_val;
    logic                      sat_flag;
    logic signed [ACC_Q_W-1:0] acc_raw_q;
    logic                      valid_q, sat_q;

    assign accept   = bus.i_valid && ready_q;
    assign tcnt_inc = tcnt_q + TCNT_W'(1);
    assign prod_d   = bus.i_data * bus.i_weight;

    // Window FSM on accepted beats: decides kill, error and the tap count
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        kill    = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            if (bus.i_first) begin
                // A first inside an open window drops the partial sum and restarts
                err_d = (state_q == MAC_ACCUM);
                if (bus.i_last) begin
                    state_d = MAC_IDLE;
                    tcnt_d  = '0;
                end else begin
                    state_d = MAC_ACCUM;
                    tcnt_d  = TCNT_W'(1);
                end
            end else if (state_q == MAC_IDLE) begin
                err_d = 1'b1;
                kill  = 1'b1;
            end else if (tcnt_inc > TCNT_W'(MAX_TAPS)) begin
                err_d   = 1'b1;
                kill    = 1'b1;
                state_d = MAC_IDLE;
                tcnt_d  = '0;
            end else if (bus.i_last) begin
                state_d = MAC_IDLE;
                tcnt_d  = '0;
            end else begin
                tcnt_d  = tcnt_inc;
            end
        end
    end

    // FSM state, tap counter, ready and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MAC_IDLE;
            tcnt_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            ready_q <= 1'b1;
            err_q   <= err_d;
        end
    end

    // Stage 1: register the exact product with its tags; kill folds into live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live1_q  <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            prod1_q  <= '0;
            bias1_q  <= '0;
        end else begin
            live1_q <= accept && !kill;
            if (accept) begin
                first1_q <= bus.i_first;
                last1_q  <= bus.i_last;
                prod1_q  <= prod_d;
                bias1_q  <= bus.i_bias;
            end
        end
    end

    assign acc_next = (first1_q ? {{GUARD{bias1_q[ACC_Q_W-1]}}, bias1_q} : acc_q)
                    + {{GUARD{prod1_q[ACC_Q_W-1]}}, prod1_q};

    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (ACC_Q_W)
    ) u_sat (
        .wide    (acc_next),
        .narrow  (sat_val),
        .clamped (sat_flag)
    );

    // Stage 2: accumulate, or emit the saturated sum on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            acc_raw_q <= '0;
            valid_q   <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (live1_q) begin
                if (last1_q) begin
                    acc_raw_q <= sat_val;
                    valid_q   <= 1'b1;
                    sat_q     <= sat_flag;
                end else begin
                    acc_q <= acc_next;
                end
            end
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_acc_raw = acc_raw_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_sat     = sat_q;
    assign bus.o_err     = err_q;

endmodule

// File: tb/tb_mac_accum_16_32.sv
// Directed self-checking bench for mac_accum_16_32.
module tb_mac_accum_16_32;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   nerr   = 0;
    logic [32:0] res_q[$];

    mac_accum_16_32_if bus ();

    mac_accum_16_32 #(
        .MAX_TAPS (64),
        .GUARD    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every emitted result {sat, acc} and count error pulses
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) res_q.push_back({bus.o_sat, bus.o_acc_raw});
        if (bus.o_err === 1'b1) nerr++;
    end

    task automatic send(input logic f, input logic l, input logic [15:0] d,
                        input logic [15:0] w, input logic [31:0] b);
        bus.i_valid  = 1'b1;
        bus.i_first  = f;
        bus.i_last   = l;
        bus.i_data   = d;
        bus.i_weight = w;
        bus.i_bias   = b;
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_first  = 1'b0;
        bus.i_last   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_first = 1'b0; bus.i_last = 1'b0;
        bus.i_data = '0; bus.i_weight = '0; bus.i_bias = '0;
        #23;
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.o_ready); end
        checks++; if (bus.o_acc_raw !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h expected 00000000", bus.o_acc_raw); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b expected 0", bus.o_sat); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.o_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", bus.o_ready); end
    endtask

    task automatic test_single_tap;
        send(1'b1, 1'b1, 16'h1000, 16'h4000, 32'h0);
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_latency_early: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", bus.o_err); end
        @(posedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.o_valid); end
        checks++; if (bus.o_acc_raw !== 32'h0400_0000) begin errors++; $display("FAIL single_acc: got %h expected 04000000", bus.o_acc_raw); end
        checks++; if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL single_sat: got %b expected 0", bus.o_sat); end
        @(posedge clk);
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b expected 0", bus.o_valid); end
        res_q.delete();
        // -1.0 x 1.0 with zero bias: negative value passes through unclamped
        send(1'b1, 1'b1, 16'hF000, 16'h4000, 32'h0);
        idle(3);
        checks++;
        if (res_q.size() !== 1) begin errors++; $display("FAIL single_neg_count: got %0d expected 1", res_q.size()); end
        else if (res_q[0] !== {1'b0, 32'hFC00_0000}) begin errors++; $display("FAIL single_neg: got %h expected 0fc000000", res_q[0]); end
    endtask

    task automatic test_back_to_back;
        int e0;
        res_q.delete();
        e0 = nerr;
        for (int i = 0; i < 4; i++) send(i == 0, i == 3, 16'h0800, 16'h2000, 32'h0400_0000);
        send(1'b1, 1'b0, 16'h1000, 16'h4000, 32'h0);
        checks++; if (bus.o_valid !== 1'b1 || bus.o_acc_raw !== 32'h0800_0000) begin
            errors++; $display("FAIL b2b_first_out: got valid=%b acc=%h expected valid=1 acc=08000000", bus.o_valid, bus.o_acc_raw); end
        for (int i = 1; i < 4; i++) send(1'b0, i == 3, 16'h1000, 16'h4000, 32'h0);
        idle(3);
        checks++;
        if (res_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", res_q.size()); end
        else if (res_q[1] !== {1'b0, 32'h1000_0000}) begin errors++; $display("FAIL b2b_second: got %h expected 010000000", res_q[1]); end
        checks++; if (nerr !== e0) begin errors++; $display("FAIL b2b_err: got %0d expected %0d", nerr, e0); end
    endtask

    task automatic test_saturation;
        res_q.delete();
        for (int i = 0; i < 64; i++) send(i == 0, i == 63, 16'h8000, 16'h8000, 32'h0);
        idle(3);
        checks++;
        if (res_q.size() !== 1) begin errors++; $display("FAIL sat_pos_count: got %0d expected 1", res_q.size()); end
        else if (res_q[0] !== {1'b1, 32'h7FFF_FFFF}) begin errors++; $display("FAIL sat_pos: got %h expected 17fffffff", res_q[0]); end
        res_q.delete();
        for (int i = 0; i < 64; i++) send(i == 0, i == 63, 16'h8000, 16'h7FFF, 32'h0);
        idle(3);
        checks++;
        if (res_q.size() !== 1) begin errors++; $display("FAIL sat_neg_count: got %0d expected 1", res_q.size()); end
        else if (res_q[0] !== {1'b1, 32'h8000_0000}) begin errors++; $display("FAIL sat_neg: got %h expected 180000000", res_q[0]); end
    endtask

    task automatic test_first_mid_window;
        int e0;
        res_q.delete();
        e0 = nerr;
        send(1'b1, 1'b0, 16'h1000, 16'h4000, 32'h0);
        send(1'b0, 1'b0, 16'h1000, 16'h4000, 32'h0);
        send(1'b0, 1'b0, 16'h1000, 16'h4000, 32'h0);
        send(1'b1, 1'b0, 16'h1000, 16'h4000, 32'h0010_0000);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL mid_first_err: got %b expected 1", bus.o_err); end
        send(1'b0, 1'b1, 16'h1000, 16'h4000, 32'h0);
        checks++; if (bus.o_err !== 1'b0) begin errors++; $display("FAIL mid_first_err_pulse: got %b expected 0", bus.o_err); end
        idle(3);
        checks++; if (nerr !== e0 + 1) begin errors++; $display("FAIL mid_first_err_count: got %0d expected %0d", nerr, e0 + 1); end
        checks++;
        if (res_q.size() !== 1) begin errors++; $display("FAIL mid_first_count: got %0d expected 1", res_q.size()); end
        else if (res_q[0] !== {1'b0, 32'h0810_0000}) begin errors++; $display("FAIL mid_first_result: got %h expected 008100000", res_q[0]); end
    endtask

    task automatic test_protocol_errors;
        int e0;
        res_q.delete();
        e0 = nerr;
        send(1'b0, 1'b0, 16'h1000, 16'h4000, 32'h0);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL idle_orphan_err: got %b expected 1", bus.o_err); end
        idle(3);
        checks++; if (nerr !== e0 + 1 || res_q.size() !== 0) begin
            errors++; $display("FAIL idle_orphan_effect: got errs=%0d outs=%0d expected errs=%0d outs=0", nerr, res_q.size(), e0 + 1); end
        for (int i = 0; i < 65; i++) send(i == 0, i == 64, 16'h1000, 16'h4000, 32'h0);
        checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL overlong_err: got %b expected 1", bus.o_err); end
        idle(3);
        checks++; if (nerr !== e0 + 2 || res_q.size() !== 0) begin
            errors++; $display("FAIL overlong_effect: got errs=%0d outs=%0d expected errs=%0d outs=0", nerr, res_q.size(), e0 + 2); end
        send(1'b1, 1'b0, 16'h0800, 16'h2000, 32'h0);
        send(1'b0, 1'b1, 16'h0800, 16'h2000, 32'h0);
        idle(3);
        checks++;
        if (res_q.size() !== 1) begin errors++; $display("FAIL after_err_count: got %0d expected 1", res_q.size()); end
        else if (res_q[0] !== {1'b0, 32'h0200_0000}) begin errors++; $display("FAIL after_err_result: got %h expected 002000000", res_q[0]); end
        checks++; if (nerr !== e0 + 2) begin errors++; $display("FAIL after_err_errcount: got %0d expected %0d", nerr, e0 + 2); end
    endtask

    task automatic test_reset_mid_window;
        res_q.delete();
        send(1'b1, 1'b0, 16'h1000, 16'h4000, 32'h0);
        send(1'b0, 1'b0, 16'h1000, 16'h4000, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_ready !== 1'b0 || bus.o_acc_raw !== 32'h0) begin
            errors++; $display("FAIL async_reset_data: got ready=%b acc=%h expected ready=0 acc=00000000", bus.o_ready, bus.o_acc_raw); end
        checks++; if (bus.o_valid !== 1'b0 || bus.o_sat !== 1'b0 || bus.o_err !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got valid=%b sat=%b err=%b expected 0 0 0", bus.o_valid, bus.o_sat, bus.o_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 1'b1, 16'h1000, 16'h1000, 32'h0000_0001);
        idle(3);
        checks++;
        if (res_q.size() !== 1) begin errors++; $display("FAIL post_reset_count: got %0d expected 1", res_q.size()); end
        else if (res_q[0] !== {1'b0, 32'h0100_0001}) begin errors++; $display("FAIL post_reset_result: got %h expected 001000001", res_q[0]); end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_back_to_back();
        test_saturation();
        test_first_mid_window();
        test_protocol_errors();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
